gray_step_arbiter: RTL and testbench

//  Shares one 3-bit gray-code counter between two requesters. A requester asks for a

---
 rtl/gray_step_arbiter.sv | 145 ++++++++++++++
 tb/tb_gray_step_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter
// Round-robin arbiter that lends one 3-bit gray counter to two requesters.
// The winner gets a burst of N counter enables, optionally after a counter
// clear, and the final gray value and overflow flag are returned with a
// one-cycle done pulse on the owner's bit.

module gray_step_arbiter #(
    parameter int STEP_W       = 4,
    parameter bit CLR_ON_GRANT = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [1:0]        req,
    input  logic [STEP_W-1:0] req_steps0,
    input  logic [STEP_W-1:0] req_steps1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic [1:0]        done,
    output logic [2:0]        result,
    output logic              result_ovf,
    output logic              cnt_en,
    output logic              cnt_clr,
    input  logic [2:0]        cnt_val,
    input  logic              cnt_ovf
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT,
        REPORT
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [STEP_W-1:0] rem;
    logic [STEP_W-1:0] remNext;
    logic              owner;
    logic              ownerNext;
    logic              lastGnt;
    logic              lastGntNext;
    logic [2:0]        resultNext;
    logic              resultOvfNext;
    logic              winner;
    logic [STEP_W-1:0] winnerSteps;

    // Pick the winner: a lone requester wins, on contention the one that did not go last
    always_comb begin
        winner      = req[1] & (~req[0] | ~lastGnt);
        winnerSteps = winner ? req_steps1 : req_steps0;
    end

    // Next-state, datapath next values and Moore outputs of the burst FSM
    always_comb begin
        nextState     = state;
        remNext       = rem;
        ownerNext     = owner;
        lastGntNext   = lastGnt;
        resultNext    = result;
        resultOvfNext = result_ovf;
        cnt_en        = 1'b0;
        done          = 2'b00;
        gnt           = 2'b00;

        if (state != IDLE) begin
            gnt[owner] = 1'b1;
        end

        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    ownerNext = winner;
                    remNext   = winnerSteps;
                    if (CLR_ON_GRANT) begin
                        nextState = CLEAR;
                    end else if (winnerSteps == '0) begin
                        nextState     = REPORT;
                        resultNext    = cnt_val;
                        resultOvfNext = cnt_ovf;
                    end else begin
                        nextState = RUN;
                    end
                end
            end
            CLEAR: begin
                if (rem == '0) begin
                    // The counter is cleared on this same edge, so its stale output is not used
                    nextState     = REPORT;
                    resultNext    = 3'b000;
                    resultOvfNext = 1'b0;
                end else begin
                    nextState = RUN;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (rem == STEP_W'(1)) begin
                    nextState = WAIT;
                end else begin
                    remNext = rem - STEP_W'(1);
                end
            end
            WAIT: begin
                nextState     = REPORT;
                resultNext    = cnt_val;
                resultOvfNext = cnt_ovf;
            end
            REPORT: begin
                done[owner] = 1'b1;
                lastGntNext = owner;
                nextState   = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Status and counter-clear outputs; the counter is cleared along with this block
    always_comb begin
        busy    = (state != IDLE);
        cnt_clr = Reset | (state == CLEAR);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            rem        <= '0;
            owner      <= 1'b0;
            lastGnt    <= 1'b1;
            result     <= 3'b000;
            result_ovf <= 1'b0;
        end else begin
            state      <= nextState;
            rem        <= remNext;
            owner      <= ownerNext;
            lastGnt    <= lastGntNext;
            result     <= resultNext;
            result_ovf <= resultOvfNext;
        end
    end

endmodule

// File: tb/tb_gray_step_arbiter.sv
// tb_gray_step_arbiter
// Drives two arbiters (clear-on-grant and continue mode), each wired to its own
// behavioural gray counter, and checks bursts through an expectation queue.

module tb_gray_step_arbiter;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    logic [1:0] reqA, gntA, doneA;
    logic [3:0] stepsA0, stepsA1;
    logic       busyA, resultOvfA, cntEnA, cntClrA, cntOvfA;
    logic [2:0] resultA, cntValA;

    logic [1:0] reqB, gntB, doneB;
    logic [3:0] stepsB0, stepsB1;
    logic       busyB, resultOvfB, cntEnB, cntClrB, cntOvfB;
    logic [2:0] resultB, cntValB;

    gray_step_arbiter #(.STEP_W(4), .CLR_ON_GRANT(1'b1)) dutA (
        .Clk(Clk), .Reset(Reset), .req(reqA), .req_steps0(stepsA0), .req_steps1(stepsA1),
        .gnt(gntA), .busy(busyA), .done(doneA), .result(resultA), .result_ovf(resultOvfA),
        .cnt_en(cntEnA), .cnt_clr(cntClrA), .cnt_val(cntValA), .cnt_ovf(cntOvfA)
    );

    gray_step_arbiter #(.STEP_W(4), .CLR_ON_GRANT(1'b0)) dutB (
        .Clk(Clk), .Reset(Reset), .req(reqB), .req_steps0(stepsB0), .req_steps1(stepsB1),
        .gnt(gntB), .busy(busyB), .done(doneB), .result(resultB), .result_ovf(resultOvfB),
        .cnt_en(cntEnB), .cnt_clr(cntClrB), .cnt_val(cntValB), .cnt_ovf(cntOvfB)
    );

    function automatic logic [2:0] nextGray(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        b = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    // Gray counter owned by arbiter A: registered output, sticky overflow on wrap
    always @(posedge Clk) begin
        if (cntClrA) begin
            cntValA <= 3'b000;
            cntOvfA <= 1'b0;
        end else if (cntEnA) begin
            cntValA <= nextGray(cntValA);
            if (cntValA == 3'b100) cntOvfA <= 1'b1;
        end
    end

    // Gray counter owned by arbiter B
    always @(posedge Clk) begin
        if (cntClrB) begin
            cntValB <= 3'b000;
            cntOvfB <= 1'b0;
        end else if (cntEnB) begin
            cntValB <= nextGray(cntValB);
            if (cntValB == 3'b100) cntOvfB <= 1'b1;
        end
    end

    typedef struct {
        logic [1:0] done;
        logic [2:0] result;
        logic       ovf;
        int         steps;
        int         lat;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t eA, eB;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   startA, startB, enCntA, enCntB;
    logic prevBusyA = 1'b0;
    logic prevBusyB = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor A: pops one expectation per done pulse and checks result, timing and enable count
    always @(negedge Clk) begin
        if (Reset) begin
            prevBusyA = 1'b0;
        end else begin
            if (busyA && !prevBusyA) begin
                startA = cyc;
                enCntA = 0;
            end
            if (cntEnA) enCntA++;
            if (doneA != 2'b00) begin
                if (qA.size() == 0) begin
                    checkOutput("A unexpected done", {30'd0, doneA}, 32'd0);
                end else begin
                    eA = qA.pop_front();
                    checkOutput("A done", {30'd0, doneA}, {30'd0, eA.done});
                    checkOutput("A gnt", {30'd0, gntA}, {30'd0, eA.done});
                    checkOutput("A result", {29'd0, resultA}, {29'd0, eA.result});
                    checkOutput("A result_ovf", {31'd0, resultOvfA}, {31'd0, eA.ovf});
                    checkOutput("A cnt_en cycles", enCntA, eA.steps);
                    checkOutput("A latency", cyc - startA, eA.lat);
                end
            end
            prevBusyA = busyA;
        end
    end

    // Monitor B: same checks for the continue-mode arbiter
    always @(negedge Clk) begin
        if (Reset) begin
            prevBusyB = 1'b0;
        end else begin
            if (busyB && !prevBusyB) begin
                startB = cyc;
                enCntB = 0;
            end
            if (cntEnB) enCntB++;
            if (doneB != 2'b00) begin
                if (qB.size() == 0) begin
                    checkOutput("B unexpected done", {30'd0, doneB}, 32'd0);
                end else begin
                    eB = qB.pop_front();
                    checkOutput("B done", {30'd0, doneB}, {30'd0, eB.done});
                    checkOutput("B gnt", {30'd0, gntB}, {30'd0, eB.done});
                    checkOutput("B result", {29'd0, resultB}, {29'd0, eB.result});
                    checkOutput("B result_ovf", {31'd0, resultOvfB}, {31'd0, eB.ovf});
                    checkOutput("B cnt_en cycles", enCntB, eB.steps);
                    checkOutput("B latency", cyc - startB, eB.lat);
                end
            end
            prevBusyB = busyB;
        end
    end

    function automatic exp_t mk(input logic [1:0] d, input logic [2:0] r, input logic o, input int s, input int l);
        exp_t e;
        e.done = d; e.result = r; e.ovf = o; e.steps = s; e.lat = l;
        return e;
    endfunction

    task automatic doReset();
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic waitEmpty(input int sel, input int budget);
        int n;
        n = 0;
        while (((sel == 0) ? qA.size() : qB.size()) != 0 && n < budget) begin
            @(negedge Clk);
            n++;
        end
        if (n >= budget) checkOutput(sel == 0 ? "A burst timeout" : "B burst timeout", 32'd1, 32'd0);
        @(negedge Clk);
    endtask

    // Issue one request, hold it until the grant is visible, then wait for its done
    task automatic applyStimulus(input int sel, input logic [1:0] r, input logic [3:0] s0, input logic [3:0] s1);
        int n;
        @(negedge Clk);
        if (sel == 0) begin reqA = r; stepsA0 = s0; stepsA1 = s1; end
        else          begin reqB = r; stepsB0 = s0; stepsB1 = s1; end
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!((sel == 0) ? busyA : busyB) && n < 20);
        if (n >= 20) checkOutput("grant timeout", 32'd1, 32'd0);
        if (sel == 0) reqA = 2'b00; else reqB = 2'b00;
        waitEmpty(sel, 60);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        Reset = 1'b1;
        reqA = 2'b00; stepsA0 = 4'd0; stepsA1 = 4'd0;
        reqB = 2'b00; stepsB0 = 4'd0; stepsB1 = 4'd0;
        repeat (3) @(negedge Clk);

        // Reset state while Reset is held
        checkOutput("reset gnt", {30'd0, gntA}, 32'd0);
        checkOutput("reset busy", {31'd0, busyA}, 32'd0);
        checkOutput("reset done", {30'd0, doneA}, 32'd0);
        checkOutput("reset cnt_en", {31'd0, cntEnA}, 32'd0);
        checkOutput("reset cnt_clr", {31'd0, cntClrA}, 32'd1);
        checkOutput("reset result", {29'd0, resultA}, 32'd0);
        checkOutput("reset result_ovf", {31'd0, resultOvfA}, 32'd0);
        checkOutput("reset counter", {29'd0, cntValA}, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("idle cnt_clr", {31'd0, cntClrA}, 32'd0);

        // Continue mode: 5 steps then 4 steps, overflow stays latched
        $display("[TB] continue-mode bursts");
        qB.push_back(mk(2'b01, 3'b111, 1'b0, 5, 6));
        applyStimulus(1, 2'b01, 4'd5, 4'd0);
        qB.push_back(mk(2'b01, 3'b001, 1'b1, 4, 5));
        applyStimulus(1, 2'b01, 4'd4, 4'd0);

        // Single burst and full wrap with clear-on-grant
        $display("[TB] single burst and full wrap");
        qA.push_back(mk(2'b01, 3'b010, 1'b0, 3, 5));
        applyStimulus(0, 2'b01, 4'd3, 4'd0);
        qA.push_back(mk(2'b01, 3'b000, 1'b1, 8, 10));
        applyStimulus(0, 2'b01, 4'd8, 4'd0);

        // Contention from reset: 0, then 1, then 0 again
        $display("[TB] contention");
        doReset();
        qA.push_back(mk(2'b01, 3'b011, 1'b0, 2, 4));
        qA.push_back(mk(2'b10, 3'b110, 1'b0, 4, 6));
        qA.push_back(mk(2'b01, 3'b011, 1'b0, 2, 4));
        reqA = 2'b11; stepsA0 = 4'd2; stepsA1 = 4'd4;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(qA.size() <= 1 && gntA == 2'b01) && n < 100);
        if (n >= 100) checkOutput("contention timeout", 32'd1, 32'd0);
        reqA = 2'b00;
        waitEmpty(0, 60);

        // Zero-step burst
        $display("[TB] zero-step burst");
        qA.push_back(mk(2'b01, 3'b000, 1'b0, 0, 1));
        applyStimulus(0, 2'b01, 4'd0, 4'd0);

        // Reset in the middle of a burst after two steps
        $display("[TB] reset mid-burst");
        @(negedge Clk);
        reqA = 2'b01; stepsA0 = 4'd5;
        @(negedge Clk);
        reqA = 2'b00;
        n = 0;
        while (cntValA != 3'b011 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        checkOutput("mid-burst in RUN", {31'd0, cntEnA}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkOutput("abort busy", {31'd0, busyA}, 32'd0);
        checkOutput("abort gnt", {30'd0, gntA}, 32'd0);
        checkOutput("abort cnt_en", {31'd0, cntEnA}, 32'd0);
        checkOutput("abort done", {30'd0, doneA}, 32'd0);
        checkOutput("abort counter", {29'd0, cntValA}, 32'd0);
        repeat (5) @(negedge Clk);

        // After reset requester 0 wins contention again
        $display("[TB] priority after reset");
        qA.push_back(mk(2'b01, 3'b001, 1'b0, 1, 3));
        applyStimulus(0, 2'b11, 4'd1, 4'd1);

        repeat (4) @(negedge Clk);
        checkOutput("leftover A expectations", qA.size(), 32'd0);
        checkOutput("leftover B expectations", qB.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
